// File: rtl/ncc_pkg.sv
// Shared types and constants for the NCC correlator pipeline.
// Holds the score type, the peak-finder state encoding and the most negative score.
package ncc_pkg;

    localparam int SCORE_W = 16;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } peak_state_t;

    localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x, y) placement counter for the NCC peak finder.
// x runs 0..NUM_X-1 per row, y runs 0..NUM_Y-1; last flags the final placement.
module raster_counter #(
    parameter int NUM_X = 25,
    parameter int NUM_Y = 25,
    localparam int XW = $clog2(NUM_X),
    localparam int YW = $clog2(NUM_Y)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(NUM_X - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(NUM_Y - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    // NOTE: reset is synchronous and active-low, so it is tested inside the clocked
    // block rather than listed in the sensitivity list; state uses <= so every
    // register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (enable) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ncc_peak_finder.sv
// Tracks the maximum NCC score over one raster-ordered search frame and hands the
// winning placement to the host. Define NCC_PEAK_SECOND_EN to build the runner-up tracker.
module ncc_peak_finder #(
    parameter int NUM_X   = 25,
    parameter int NUM_Y   = 25,
    parameter int SCORE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       score_valid,
    input  logic signed [SCORE_W-1:0]  score,
    output logic                       score_ready,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic signed [SCORE_W-1:0]  peak_score,
    output logic [$clog2(NUM_X)-1:0]   peak_x,
    output logic [$clog2(NUM_Y)-1:0]   peak_y,
    output logic signed [SCORE_W-1:0]  second_score,
    output logic                       busy
);

    import ncc_pkg::*;

    localparam int XW = $clog2(NUM_X);
    localparam int YW = $clog2(NUM_Y);
    localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};

    peak_state_t state_q, state_d;

    logic                      accept, start_frame, last, new_best;
    logic [XW-1:0]             cur_x, best_x, best_x_d;
    logic [YW-1:0]             cur_y, best_y, best_y_d;
    logic signed [SCORE_W-1:0] best, best_d;

    assign score_ready  = (state_q == SCAN);
    assign result_valid = (state_q == HOLD);
    assign busy         = (state_q != IDLE);
    assign accept       = score_valid && score_ready;
    assign start_frame  = (state_q == IDLE) && start;

    raster_counter #(
        .NUM_X (NUM_X),
        .NUM_Y (NUM_Y)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_frame),
        .enable (accept),
        .x      (cur_x),
        .y      (cur_y),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)           state_d = SCAN;
            SCAN:    if (accept && last)  state_d = HOLD;
            HOLD:    if (result_ready)    state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Strict comparison keeps the earliest placement on ties.
    always_comb begin
        new_best = (score > best);
        best_d   = new_best ? score : best;
        best_x_d = new_best ? cur_x : best_x;
        best_y_d = new_best ? cur_y : best_y;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            best       <= '0;
            best_x     <= '0;
            best_y     <= '0;
            peak_score <= '0;
            peak_x     <= '0;
            peak_y     <= '0;
        end else if (start_frame) begin
            best   <= MIN_SCORE;
            best_x <= '0;
            best_y <= '0;
        end else if (accept) begin
            best   <= best_d;
            best_x <= best_x_d;
            best_y <= best_y_d;
            // Result registers take the final comparison on the last-accept edge.
            if (last) begin
                peak_score <= best_d;
                peak_x     <= best_x_d;
                peak_y     <= best_y_d;
            end
        end
    end

`ifdef NCC_PEAK_SECOND_EN
    logic signed [SCORE_W-1:0] second, second_d;

    always_comb begin
        second_d = second;
        if (new_best)           second_d = best;
        else if (score > second) second_d = score;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            second       <= '0;
            second_score <= '0;
        end else if (start_frame) begin
            second <= MIN_SCORE;
        end else if (accept) begin
            second <= second_d;
            if (last) second_score <= second_d;
        end
    end
`else
    assign second_score = '0;
`endif

endmodule
